data_mem_responder: RTL and testbench

Responder end of the CPU data-memory port. Takes `memwrite`/`memaddr`/`memwritedata` from the processor core and returns `memreaddata` in the same cycle. It holds the word-addressed data RAM behind a one-entry posted write buffer, plus a small memory-mapped I/O region with an LED register and a cycle timer. It sits beside the core at the top level, opposite the core's data-memory initiator port.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_timer.sv | 49 ++++
 rtl/data_mem_responder.sv | 90 +++++++++
 tb/tb_data_mem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: MMIO register offsets,
// the default MMIO page select and the compare register reset value.
package dmem_pkg;

  localparam logic [15:0] OFS_LED    = 16'h0000;
  localparam logic [15:0] OFS_COUNT  = 16'h0004;
  localparam logic [15:0] OFS_CMP    = 16'h0008;
  localparam logic [15:0] OFS_STATUS = 16'h000C;

  localparam logic [15:0] MMIO_HI_DEFAULT = 16'hFFFF;

  localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

endpackage

// File: rtl/dmem_timer.sv
// Free-running cycle timer with compare register and sticky match flag.
// Only compiled and instantiated when DMEM_TIMER_EN is defined.
`ifdef DMEM_TIMER_EN
module dmem_timer
  import dmem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] ofs,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count;
  logic [31:0] cmp;
  logic        flag;

  // The match test uses pre-edge COUNT/CMP, so a CMP write in the matching
  // cycle does not affect it, and a match wins over a STATUS clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      cmp   <= CMP_RESET;
      flag  <= 1'b0;
    end else begin
      if (wr_en && ofs == OFS_COUNT) count <= wdata;
      else                           count <= count + 32'd1;
      if (wr_en && ofs == OFS_CMP) cmp <= wdata;
      if (count == cmp)                                  flag <= 1'b1;
      else if (wr_en && ofs == OFS_STATUS && wdata[0]) flag <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_COUNT:  rdata = count;
      OFS_CMP:    rdata = cmp;
      OFS_STATUS: rdata = {31'd0, flag};
      default:    rdata = '0;
    endcase
  end

  assign irq = flag;

endmodule
`endif

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a one-entry posted write buffer plus
// an MMIO page (LED, and the timer when DMEM_TIMER_EN is defined).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [15:0] MMIO_HI     = MMIO_HI_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic [7:0]  led,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic          is_mmio;
  logic [15:0]   ofs;
  logic [AW-1:0] idx;
  logic          ram_we;
  logic          mmio_we;
  logic          unused_addr_bits;

  logic [31:0]   mem [DEPTH_WORDS];
  logic          wb_valid;
  logic [AW-1:0] wb_idx;
  logic [31:0]   wb_data;

  logic [31:0]   timer_rdata;
  logic [31:0]   mmio_rdata;
  logic [31:0]   ram_rdata;

  assign is_mmio          = (memaddr[31:16] == MMIO_HI);
  assign ofs              = {memaddr[15:2], 2'b00};
  assign idx              = memaddr[AW+1:2];
  assign ram_we           = memwrite && !is_mmio;
  assign mmio_we          = memwrite && is_mmio;
  assign unused_addr_bits = ^memaddr[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid <= 1'b0;
      wb_idx   <= '0;
      wb_data  <= '0;
    end else if (ram_we) begin
      wb_valid <= 1'b1;
      wb_idx   <= idx;
      wb_data  <= memwritedata;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Array has no reset; a buffered entry simply drains one edge after capture.
  always_ff @(posedge clk) begin
    if (wb_valid) mem[wb_idx] <= wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          led <= 8'd0;
    else if (mmio_we && ofs == OFS_LED) led <= memwritedata[7:0];
  end

`ifdef DMEM_TIMER_EN
  dmem_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .wr_en (mmio_we),
    .ofs   (ofs),
    .wdata (memwritedata),
    .rdata (timer_rdata),
    .irq   (irq)
  );
`else
  assign timer_rdata = '0;
  assign irq         = 1'b0;
`endif

  always_comb begin
    mmio_rdata  = (ofs == OFS_LED) ? {24'd0, led} : timer_rdata;
    ram_rdata   = (wb_valid && wb_idx == idx) ? wb_data : mem[idx];
    memreaddata = '0;
    if (reset) memreaddata = is_mmio ? mmio_rdata : ram_rdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, timer corner cases and
// randomized traffic against a word-level reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [7:0]  led;
  logic        irq;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_HI(16'hFFFF)) dut (
    .clk          (clk),
    .reset        (reset),
    .memwrite     (memwrite),
    .memaddr      (memaddr),
    .memwritedata (memwritedata),
    .memreaddata  (memreaddata),
    .led          (led),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a write becomes architecturally visible at the next edge;
  // the most recent write is undone if reset hits before it could drain.
  logic [31:0] ramM [DEPTH];
  bit          knownM [DEPTH];
  logic [7:0]  ledM;
  logic [31:0] countM;
  logic [31:0] cmpM;
  bit          flagM;
  bit          pendValid;
  int          pendIdx;
  logic [31:0] pendPrev;
  bit          pendPrevKnown;
  logic        sampledIrq;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
    bit          hasExp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [16];

  function automatic bit isMmio(input logic [31:0] a);
    return a[31:16] == 16'hFFFF;
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (!reset) return 32'd0;
    if (isMmio(a)) begin
      case (a[15:0])
        16'h0000: return {24'd0, ledM};
        16'h0004: return TIMER ? countM : 32'd0;
        16'h0008: return TIMER ? cmpM : 32'd0;
        16'h000C: return TIMER ? {31'd0, flagM} : 32'd0;
        default:  return 32'd0;
      endcase
    end
    return ramM[wordIdx(a)];
  endfunction

  function automatic bit modelKnown(input logic [31:0] a);
    return !reset || isMmio(a) || knownM[wordIdx(a)];
  endfunction

  task automatic resetModel();
    ledM      = 8'd0;
    countM    = 32'd0;
    cmpM      = 32'hFFFF_FFFF;
    flagM     = 1'b0;
    pendValid = 1'b0;
  endtask

  task automatic modelStep(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit match;
    bit mw;
    int i;
    if (!reset) begin
      resetModel();
      return;
    end
    match = (countM == cmpM);
    mw    = we && isMmio(a);
    if (mw && a[15:0] == 16'h0000) ledM = d[7:0];
    if (mw && a[15:0] == 16'h0004) countM = d;
    else                           countM = countM + 32'd1;
    if (mw && a[15:0] == 16'h0008) cmpM = d;
    if (match)                                  flagM = 1'b1;
    else if (mw && a[15:0] == 16'h000C && d[0]) flagM = 1'b0;
    pendValid = 1'b0;
    if (we && !isMmio(a)) begin
      i             = wordIdx(a);
      pendValid     = 1'b1;
      pendIdx       = i;
      pendPrev      = ramM[i];
      pendPrevKnown = knownM[i];
      ramM[i]       = d;
      knownM[i]     = 1'b1;
    end
  endtask

  task automatic assertReset();
    reset = 1'b0;
    if (pendValid) begin
      ramM[pendIdx]   = pendPrev;
      knownM[pendIdx] = pendPrevKnown;
    end
    resetModel();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle at posedge+1, samples at the negedge, steps the model at the posedge.
  task automatic applyStimulus(input bit we, input logic [31:0] a, input logic [31:0] d,
                               input bit hasExp, input logic [31:0] exp, input string name);
    memwrite     = we;
    memaddr      = a;
    memwritedata = d;
    @(negedge clk);
    sampledIrq = irq;
    if (modelKnown(a)) checkOutput({name, "/model_rd"}, memreaddata, modelRead(a));
    if (hasExp) checkOutput(name, memreaddata, exp);
    checkOutput({name, "/led"}, {24'd0, led}, {24'd0, ledM});
    checkOutput({name, "/irq"}, {31'd0, irq}, {31'd0, TIMER & flagM});
    @(posedge clk);
    modelStep(we, a, d);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int highs;
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] d;
    bit we;

    reset        = 1'b0;
    memwrite     = 1'b0;
    memaddr      = 32'd0;
    memwritedata = 32'd0;
    resetModel();
    @(posedge clk);
    #1;

    for (int i = 0; i < 3; i++) applyStimulus(0, 32'hFFFF_0008, 0, 1, 32'd0, "rst_rd_zero");
    reset = 1'b1;
    applyStimulus(0, 32'hFFFF_0004, 0, 1, 32'd0, "post_rst_count");
    checkOutput("post_rst_irq", {31'd0, sampledIrq}, 32'd0);
    checkOutput("post_rst_led", {24'd0, led}, 32'd0);
    applyStimulus(0, 32'hFFFF_0008, 0, 1, TIMER ? 32'hFFFF_FFFF : 32'd0, "post_rst_cmp");

    vecs[0]  = '{1'b1, 32'h0000_0100, 32'h1234_5678, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678};
    vecs[2]  = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h0,         1'b1, 32'h1234_5678};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_000A, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_0004, 32'h0000_000B, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h0000_0000, 32'h0000_000C, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0000_000C};
    vecs[9]  = '{1'b0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_000B};
    vecs[10] = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_000C};
    vecs[11] = '{1'b1, 32'hFFFF_0000, 32'h0000_01A5, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 32'hFFFF_0000, 32'h0,         1'b1, 32'h0000_00A5};
    vecs[13] = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0};
    vecs[14] = '{1'b1, 32'hFFFF_0004, 32'h0000_0005, 1'b0, 32'h0};
    vecs[15] = '{1'b0, 32'hFFFF_0004, 32'h0,         1'b1, TIMER ? 32'd5 : 32'd0};

    for (int i = 0; i < 16; i++)
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].hasExp, vecs[i].exp,
                    $sformatf("vec%0d", i));
    checkOutput("led_a5", {24'd0, led}, 32'h0000_00A5);

`ifdef DMEM_TIMER_EN
    applyStimulus(1, 32'hFFFF_0004, 32'd1000, 0, 0, "cnt_park");
    applyStimulus(1, 32'hFFFF_0008, 32'd20, 0, 0, "cmp_20");
    applyStimulus(1, 32'hFFFF_0004, 32'd10, 0, 0, "cnt_10");
    n = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 32'hFFFF_000C, 0, 0, 0, "irq_wait");
      if (sampledIrq) break;
      n++;
    end
    checkOutput("irq_rise_delay", 32'(n), 32'd11);
    applyStimulus(1, 32'hFFFF_000C, 32'd1, 0, 0, "status_clr");
    applyStimulus(0, 32'hFFFF_000C, 0, 1, 32'd0, "status_after_clr");
    checkOutput("irq_after_clr", {31'd0, sampledIrq}, 32'd0);
    v = countM + 32'd3;
    applyStimulus(1, 32'hFFFF_0008, v, 0, 0, "cmp_near");
    applyStimulus(0, 32'hFFFF_0008, 0, 1, v, "cmp_readback");
    applyStimulus(0, 32'hFFFF_000C, 0, 1, 32'd0, "pre_match");
    applyStimulus(1, 32'hFFFF_000C, 32'd1, 0, 0, "clr_at_match");
    applyStimulus(0, 32'hFFFF_000C, 0, 1, 32'd1, "set_beats_clr");
    checkOutput("irq_set_beats_clr", {31'd0, sampledIrq}, 32'd1);
    applyStimulus(1, 32'hFFFF_000C, 32'd1, 0, 0, "status_clr2");
`else
    highs = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 32'hFFFF_000C, 0, 1, 32'd0, "notimer_idle");
      if (sampledIrq !== 1'b0) highs++;
    end
    checkOutput("notimer_irq_100", 32'(highs), 32'd0);
`endif

    applyStimulus(1, 32'h0000_0200, 32'h11, 0, 0, "rstmid_old");
    applyStimulus(0, 32'h0000_0300, 0, 0, 0, "rstmid_gap");
    applyStimulus(1, 32'h0000_0200, 32'h22, 0, 0, "rstmid_new");
    assertReset();
    applyStimulus(0, 32'h0000_0200, 0, 1, 32'd0, "rstmid_rd_in_rst");
    applyStimulus(0, 32'hFFFF_0000, 0, 1, 32'd0, "rstmid_led_in_rst");
    reset = 1'b1;
    applyStimulus(0, 32'h0000_0200, 0, 1, 32'h11, "rstmid_discard");
    checkOutput("rstmid_led", {24'd0, led}, 32'd0);

    for (int i = 0; i < 500; i++) begin
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      if ($urandom_range(0, 3) == 0)
        a = 32'hFFFF_0000 | (32'($urandom_range(0, 4)) << 2);
      else
        a = ($urandom & 32'hFFFE_0000) | (32'($urandom_range(0, 15)) << 2)
            | (32'($urandom_range(0, 1)) << 12);
      applyStimulus(we, a, d, 0, 0, "rand");
      if ($urandom_range(0, 99) == 0) begin
        assertReset();
        applyStimulus(0, a, 0, 1, 32'd0, "rand_rst");
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
